// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: data/function widths,
// the six supported function codes, port index encoding and a helper
// that tells whether a function code is handled by the shared ALU.
package alu_arbiter_pkg;

    localparam int FUNCT_W = 6;
    localparam int DATA_W  = 32;

    // Port index encoding
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Function codes understood by the shared ALU
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'b000010;

    function automatic logic fn_supported(input logic [FUNCT_W-1:0] fn);
        case (fn)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL: fn_supported = 1'b1;
            default:                                      fn_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational grant picker for the two ALU requesters.
// Default build: round-robin on contention, using LastGnt (the port that
// won the most recent accepted grant) to hand the next contention to the
// other port. With ALU_ARB_FIXED_PRI_EN defined, port 0 always wins and
// LastGnt is ignored. Hold suppresses both grants.
module alu_rr_pick (
    input  logic Req0,
    input  logic Req1,
    input  logic LastGnt,
    input  logic Hold,
    output logic Gnt0,
    output logic Gnt1
);

`ifdef ALU_ARB_FIXED_PRI_EN
    // Port 0 has absolute priority
    assign Gnt0 = ~Hold & Req0;
    assign Gnt1 = ~Hold & Req1 & ~Req0;
`else
    // On contention the port that did not win last time is granted
    assign Gnt0 = ~Hold & Req0 & (~Req1 |  LastGnt);
    assign Gnt1 = ~Hold & Req1 & (~Req0 | ~LastGnt);
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter and issue sequencer in front of one shared 32-bit ALU.
// A grant accepted at edge t drives the operands on Alu* during cycle t+1;
// the ALU result is captured and returned as a one-cycle ValidN strobe in
// cycle t+2. Unsupported function codes return 0 with ErrN set.
// Optional macro ALU_ARB_FIXED_PRI_EN: fixed priority to port 0, no
// LastGnt register.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    input  logic               Hold,
    input  logic               Req0,
    input  logic               Req1,
    input  logic [FUNCT_W-1:0] Signal0,
    input  logic [FUNCT_W-1:0] Signal1,
    input  logic [DATA_W-1:0]  DataA0,
    input  logic [DATA_W-1:0]  DataB0,
    input  logic [DATA_W-1:0]  DataA1,
    input  logic [DATA_W-1:0]  DataB1,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic               Valid0,
    output logic               Valid1,
    output logic [DATA_W-1:0]  Result0,
    output logic [DATA_W-1:0]  Result1,
    output logic               Err0,
    output logic               Err1,
    output logic [FUNCT_W-1:0] AluSignal,
    output logic [DATA_W-1:0]  AluDataA,
    output logic [DATA_W-1:0]  AluDataB,
    input  logic [DATA_W-1:0]  AluDataOut,
    output logic               Busy
);

    logic               pick_gnt0;
    logic               pick_gnt1;
    logic               last_gnt;
    logic               acc0;
    logic               acc1;
    logic               accept;

    logic               issue_vld_reg;
    logic               issue_port_reg;
    logic [FUNCT_W-1:0] issue_sig_reg;
    logic [DATA_W-1:0]  issue_a_reg;
    logic [DATA_W-1:0]  issue_b_reg;

    logic               res_vld_reg;
    logic               res_port_reg;
    logic               res_err_reg;
    logic [DATA_W-1:0]  res_data_reg;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign last_gnt = PORT1;
`else
    logic last_gnt_reg;

    // Remember which port won the latest accepted grant; reset favours port 0 next
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            last_gnt_reg <= PORT1;
        end else if (accept) begin
            last_gnt_reg <= acc1;
        end
    end

    assign last_gnt = last_gnt_reg;
`endif

    alu_rr_pick u_pick (
        .Req0    (Req0),
        .Req1    (Req1),
        .LastGnt (last_gnt),
        .Hold    (Hold),
        .Gnt0    (pick_gnt0),
        .Gnt1    (pick_gnt1)
    );

    // Grants are forced low while reset is asserted
    assign Gnt0   = pick_gnt0 & ~Reset;
    assign Gnt1   = pick_gnt1 & ~Reset;
    assign acc0   = Req0 & Gnt0;
    assign acc1   = Req1 & Gnt1;
    assign accept = acc0 | acc1;

    // Issue stage: capture the winner's function code and operands
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            issue_vld_reg  <= 1'b0;
            issue_port_reg <= PORT0;
            issue_sig_reg  <= '0;
            issue_a_reg    <= '0;
            issue_b_reg    <= '0;
        end else begin
            issue_vld_reg <= accept;
            if (accept) begin
                issue_port_reg <= acc1 ? PORT1 : PORT0;
                issue_sig_reg  <= acc1 ? Signal1 : Signal0;
                issue_a_reg    <= acc1 ? DataA1  : DataA0;
                issue_b_reg    <= acc1 ? DataB1  : DataB0;
            end
        end
    end

    // Shared ALU sees zeros whenever no operation is issued
    assign AluSignal = issue_vld_reg ? issue_sig_reg : '0;
    assign AluDataA  = issue_vld_reg ? issue_a_reg   : '0;
    assign AluDataB  = issue_vld_reg ? issue_b_reg   : '0;

    // Result stage: capture the ALU output, zeroing it for unsupported codes
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            res_vld_reg  <= 1'b0;
            res_port_reg <= PORT0;
            res_err_reg  <= 1'b0;
            res_data_reg <= '0;
        end else begin
            res_vld_reg  <= issue_vld_reg;
            res_port_reg <= issue_port_reg;
            res_err_reg  <= issue_vld_reg & ~fn_supported(issue_sig_reg);
            res_data_reg <= (issue_vld_reg && fn_supported(issue_sig_reg)) ? AluDataOut : '0;
        end
    end

    // Per-port result demux; the non-selected port reads all zeros
    logic [1:0]        valid_vec;
    logic [1:0]        err_vec;
    logic [DATA_W-1:0] result_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign valid_vec[gi]  = res_vld_reg & (res_port_reg == 1'(gi));
        assign err_vec[gi]    = valid_vec[gi] & res_err_reg;
        assign result_vec[gi] = valid_vec[gi] ? res_data_reg : '0;
    end

    assign Valid0  = valid_vec[0];
    assign Valid1  = valid_vec[1];
    assign Err0    = err_vec[0];
    assign Err1    = err_vec[1];
    assign Result0 = result_vec[0];
    assign Result1 = result_vec[1];

    assign Busy = issue_vld_reg | res_vld_reg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and issue sequencer that shares the single 32-bit integer ALU between two requesters, typically the EX stage and an auxiliary multi-cycle unit such as a branch/address helper. Each cycle it grants at most one request, registers the winner's function code and operands, drives them to the shared ALU, and captures the result. It then returns the result to the originating port two cycles after the grant, tagged with an error flag for unsupported function codes.

## Interface

- No parameters. Data width is fixed at 32 bits and the function code at 6 bits.
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Hold  in  1  when high, no grants are issued and the in-flight pipeline still drains
- Req0 / Req1  in  1  request from port 0 / port 1
- Signal0 / Signal1  in  6  function code per port
- DataA0, DataB0 / DataA1, DataB1  in  32  operands per port
- Gnt0 / Gnt1  out  1  combinational grant; the transaction is accepted at the clock edge that closes a cycle with ReqN & GntN
- Valid0 / Valid1  out  1  one-cycle result strobe per port
- Result0 / Result1  out  32  result per port, meaningful only while ValidN is high
- Err0 / Err1  out  1  unsupported function code, qualified by ValidN
- AluSignal  out  6  function code driven to the shared ALU
- AluDataA, AluDataB  out  32  operands driven to the shared ALU
- AluDataOut  in  32  combinational ALU result
- Busy  out  1  high while any issue or result stage holds a live operation

## Operation

- **Supported function codes:** AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010.
- **Grant rule, no Hold:**
  - If only one port requests, that port is granted.
  - If both ports request, the port not granted most recently wins (round-robin).
  - The LastGnt pointer updates only when a grant is accepted. It resets to 1, so port 0 wins the first contention.
- **Issue stage:** registers issue_vld, issue_port, issue_sig, issue_a, issue_b from the granted port.
  - The Alu* outputs are driven directly from these registers.
  - When issue_vld = 0, the Alu* outputs are 0.
- **Result stage:** captures AluDataOut, issue_port and issue_vld at the next edge.
  - If issue_sig is unsupported, the result is forced to 0 and Err is set.
- **Result outputs:** ValidN = res_vld & (res_port == N). ResultN and ErrN follow the result registers and are 0 on the non-selected port.
- **Busy** = issue_vld | res_vld.
- **Hold:** Gnt0 = Gnt1 = 0 and the issue stage loads issue_vld = 0. Stages already loaded continue and deliver their results.
- **Requester contract:** keep ReqN, SignalN and operands stable until GntN is seen. The next request may be presented in the following cycle.

## Timing

- **Latency:** a grant accepted at edge t puts the operands on Alu* during cycle t+1. ValidN is high during cycle t+2, for exactly one cycle.
- **Throughput:** one operation per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- **Simultaneous requests:** the two ports alternate every cycle while both are held high.
- **Reset asserted:**
  - Every register clears immediately and asynchronously.
  - All outputs are 0, including Gnt0/Gnt1 (gated by Reset), Valid*, Result*, Err*, Alu* and Busy.
  - LastGnt is set to 1.
- **Reset asserted mid-operation:** operations in flight are discarded and produce no Valid.
- **First cycle after Reset deasserts:** requests may be granted.
- **Arithmetic:** the arbiter does no arithmetic. ALU results pass unmodified, including SUB wrap-around and the SLT 0/1 result.

## Configuration

- **Macro:** ALU_ARB_FIXED_PRI_EN.
- **Defined:** fixed priority. Port 0 wins whenever Req0 is high, and the LastGnt register is not built.
- **Undefined (default):** round-robin as described under Operation.

## Structure

- **Shared package / include:** the six function-code constants, the FUNCT_W=6 and DATA_W=32 constants, and the port-index encoding (0/1).
- **Sub-module:** alu_rr_pick, a combinational picker with inputs Req0, Req1, LastGnt, Hold and outputs Gnt0, Gnt1.
  - The pipeline registers and result demux stay in alu_arbiter.
  - The shared ALU is instantiated outside the arbiter, alongside it.

## Test plan

- Reset held for 3 cycles with Req0=1 -> Gnt0=0, all outputs 0. After release, Req0 ADD 5+7 is granted at the first edge, and Valid0=1, Result0=12, Err0=0 two cycles later.
- Req0 and Req1 both held high for 4 cycles: port 0 SUB 10-3, port 1 OR 0xF0|0x0F -> grants ordered 0,1,0,1. Valid0 shows 7, and Valid1 shows 0x000000FF in alternating cycles.
- Req1 SLT 0xFFFFFFFF vs 1 -> Valid1, Result1=1. Req1 SUB 0-1 -> Result1=0xFFFFFFFF.
- Req0 with Signal0=111111 -> granted, Valid0=1, Result0=0, Err0=1.
- Hold=1 for 2 cycles while one operation is in flight and Req0 is high -> the in-flight result is still delivered and no Gnt0 is issued. After Hold drops, Gnt0 asserts in the same cycle.
- Reset pulsed one cycle after a grant -> no Valid appears, and Busy=0 the cycle after release.
- With ALU_ARB_FIXED_PRI_EN defined and both ports requesting for 3 cycles -> Gnt0 on all 3 cycles, Gnt1 never.
